// File: rtl/multi_gate_pipe.sv
// Registered N-operand bitwise gate with an optional running accumulator.
// Each result bit is computed by its own lane instance; a valid/ready register stage holds it.

module mgp_lane #(
  parameter int NUM_IN = 4
) (
  input  logic [NUM_IN-1:0] bits,
  input  logic [1:0]        base_sel,
  input  logic              inv,
  input  logic              use_acc,
  input  logic              acc_bit,
  output logic              fold_bit,
  output logic              res_bit
);
  logic red;
  logic with_acc;

  always_comb begin
    red      = 1'b0;
    with_acc = 1'b0;
    unique case (base_sel)
      2'd0: begin
        red      = &bits;
        with_acc = red & acc_bit;
      end
      2'd1: begin
        red      = |bits;
        with_acc = red | acc_bit;
      end
      default: begin
        red      = ^bits;
        with_acc = red ^ acc_bit;
      end
    endcase
  end

  // Inversion is applied after the fold so NAND/NOR/XNOR accumulate on the base function.
  assign fold_bit = use_acc ? with_acc : red;
  assign res_bit  = inv ? ~fold_bit : fold_bit;
endmodule

module multi_gate_pipe #(
  parameter int WIDTH  = 8,
  parameter int NUM_IN = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [NUM_IN*WIDTH-1:0] data_in,
  input  logic [2:0]              op,
  input  logic                    acc_mode,
  input  logic                    acc_clr,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [WIDTH-1:0]        y,
  output logic                    y_any,
  output logic                    op_err
);
  typedef enum logic [1:0] {
    BASE_AND = 2'd0,
    BASE_OR  = 2'd1,
    BASE_XOR = 2'd2
  } base_e;

  base_e                          base;
  logic                           inv;
  logic                           is_pass;
  logic                           is_ill;
  logic [WIDTH-1:0]               acc;
  logic [WIDTH-1:0]               ident;
  logic [WIDTH-1:0]               acc_src;
  logic [WIDTH-1:0]               fold;
  logic [WIDTH-1:0]               res;
  logic [WIDTH-1:0]               y_next;
  logic [WIDTH-1:0][NUM_IN-1:0]   lane_bits;
  logic                           accept;
  logic                           consume;
  logic                           fold_beat;

  always_comb begin
    base    = BASE_OR;
    inv     = 1'b0;
    is_pass = 1'b0;
    is_ill  = 1'b0;
    unique case (op)
      3'b000: base = BASE_AND;
      3'b001: base = BASE_OR;
      3'b010: base = BASE_XOR;
      3'b011: begin base = BASE_AND; inv = 1'b1; end
      3'b100: begin base = BASE_OR;  inv = 1'b1; end
      3'b101: begin base = BASE_XOR; inv = 1'b1; end
      3'b110: is_pass = 1'b1;
      default: is_ill = 1'b1;
    endcase
  end

  // PASS and illegal decode to OR class, so their clear value is zero.
  assign ident   = (base == BASE_AND) ? '1 : '0;
  assign acc_src = acc_clr ? ident : acc;

  genvar b, k;
  generate
    for (b = 0; b < WIDTH; b++) begin : g_lane
      for (k = 0; k < NUM_IN; k++) begin : g_tap
        assign lane_bits[b][k] = data_in[k*WIDTH + b];
      end
      mgp_lane #(.NUM_IN(NUM_IN)) u_lane (
        .bits     (lane_bits[b]),
        .base_sel (base),
        .inv      (inv),
        .use_acc  (acc_mode),
        .acc_bit  (acc_src[b]),
        .fold_bit (fold[b]),
        .res_bit  (res[b])
      );
    end
  endgenerate

  assign y_next    = is_ill ? '0 : (is_pass ? data_in[WIDTH-1:0] : res);
  assign in_ready  = !out_valid || out_ready;
  assign accept    = in_valid && in_ready;
  assign consume   = out_valid && out_ready;
  assign fold_beat = accept && acc_mode && !is_pass && !is_ill;

  // A clear with no folding beat still lands; with a folding beat it is merged via acc_src.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)            acc <= '0;
    else if (fold_beat) acc <= fold;
    else if (acc_clr)   acc <= ident;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      y         <= '0;
      y_any     <= 1'b0;
      op_err    <= 1'b0;
    end else begin
      if (accept) begin
        y      <= y_next;
        y_any  <= |y_next;
        op_err <= is_ill;
      end
      if (accept)       out_valid <= 1'b1;
      else if (consume) out_valid <= 1'b0;
    end
  end
endmodule

// File: doc/multi_gate_pipe.md
Name: multi_gate_pipe

Overview:
- Parametrised successor of the single 2-input gate.
- Applies a selectable bitwise logic function across NUM_IN operands of WIDTH bits each.
- Registers the result behind a valid/ready handshake, with an optional running-accumulate mode.
- Sits between operand producers and downstream logic as a reusable registered gate stage.

Parameters:
- WIDTH, 8, bit width of each operand and of the result.
- NUM_IN, 4, number of operands; legal range 2..16.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  operand beat present.
- in_ready  output  1  block can accept a beat.
- data_in  input  NUM_IN*WIDTH  packed operands; operand k = data_in[k*WIDTH +: WIDTH].
- op  input  3  function select, sampled with the beat.
- acc_mode  input  1  1 = fold the beat into the accumulator; 0 = stateless.
- acc_clr  input  1  reset the accumulator to the identity value.
- out_valid  output  1  result register holds an unconsumed result.
- out_ready  input  1  downstream accepts the result.
- y  output  WIDTH  registered result.
- y_any  output  1  registered OR-reduction of y.
- op_err  output  1  registered; 1 if the result came from an illegal op.

Behaviour:
- Reset (async, rst=1): out_valid=0, y=0, y_any=0, op_err=0, acc=0, in_ready=1 after release.
- Handshake:
  - in_ready = !out_valid || out_ready (combinational).
  - A beat is accepted when in_valid && in_ready.
  - The output is consumed when out_valid && out_ready.
  - Latency is 1 cycle: an accepted beat appears on y/out_valid at the next edge.
  - Full throughput: one beat per cycle while out_ready=1.
- Backpressure: while out_valid && !out_ready, y, y_any and op_err hold and in_ready=0.
- out_valid next = accepted ? 1 : (consumed ? 0 : out_valid).
- op encoding:
  - 000 AND, 001 OR, 010 XOR, 011 NAND, 100 NOR, 101 XNOR, 110 PASS (operand 0).
  - 111 illegal: y=0, op_err=1, accumulator untouched.
  - Any legal op sets op_err=0.
- Base function: AND for 000/011, OR for 001/100, XOR for 010/101. B = base function folded over all NUM_IN operands.
- Inversion: NAND/NOR/XNOR apply a bitwise invert after the base function, including after accumulation.
- acc_mode=0:
  - y = (inverted?) B.
  - Accumulator is unchanged.
- acc_mode=1, legal non-PASS op:
  - acc_next = base(acc, B); y = (inverted?) acc_next.
- acc_mode=1 with PASS: y = operand 0; accumulator unchanged.
- acc_clr:
  - Sets the accumulator to the identity of the current op's base function: all-ones for AND-class, 0 otherwise.
  - Takes effect at the next edge, independent of in_valid/in_ready; produces no output beat.
  - acc_clr together with an accepted acc_mode beat: clear first, then fold, so acc_next = B.
- Changing op between accumulate beats without acc_clr is legal: the new base function is applied to the existing accumulator value.
- Operand width is preserved; no carries and no truncation.
- y_any = |y, computed from the next y value and registered with it.
- Reset asserted mid-stream: pending output is dropped (out_valid=0) and the accumulator clears immediately.
- An accepted beat never alters the registered output in the same cycle.

Test Plan:
- Stateless ops, WIDTH=8, NUM_IN=4, operands {0xF0,0x3C,0xFF,0x0F}:
  - op=000 -> y=0x00, y_any=0.
  - op=001 -> y=0xFF.
  - op=010 -> y=0x3C.
  - op=011 -> y=0xFF.
  - op=110 -> y=0xF0.
  - Each result appears one cycle after acceptance.
- Illegal op 111 with any data -> y=0x00, op_err=1, out_valid=1. A following op=001 beat clears op_err to 0.
- Backpressure: hold out_ready=0 after one beat -> in_ready=0, y held for 5 cycles. Raise out_ready -> that beat is consumed and the next beat is accepted the same cycle, with no loss or duplication across 20 random beats.
- Accumulate OR:
  - acc_clr, then beats 0x01, 0x02, 0x80 (other operands 0), op=001, acc_mode=1 -> y = 0x01, 0x03, 0x83.
  - acc_clr simultaneous with beat 0x10 -> y=0x10.
- Accumulate XNOR: acc_clr with op=101, then two beats B=0x55 -> y = 0xAA, then 0xFF.
- Async reset asserted mid-accumulation with out_valid=1 -> out_valid, y, op_err and acc go to 0 without a clock edge. The next OR beat 0x04 -> y=0x04.
